mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and write-back stage of the 16-bit pipelined processor. Consumes the control and data signals that the decode stage pipelines downstream, performs data-memory loads and stores, and drives the register-file write port (`write_addr`, `write_data`, `write_en`) back into the decode stage, closing the pipeline loop. It also carries the destination register number along the pipeline so that it is time-aligned with the write-back control bit, and it keeps a retirement counter.

## Interface
- `ADDR_W`, default 8: data-memory address width; depth is 2^ADDR_W words of 16 bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all pipeline registers and the counter.
- `ex_alu_result`  in  16: ALU result; memory address for loads and stores, write-back data otherwise.
- `ex_store_data`  in  16: store operand (decode `read_data2`, delayed two stages).
- `ex_dest_addr`  in  3: destination register number.
- `ex_mem_read`  in  1: load.
- `ex_mem_write`  in  1: store.
- `ex_wb`  in  1: instruction writes the register file.
- `write_addr`  out  3: register-file write address.
- `write_data`  out  16: register-file write data.
- `write_en`  out  1: register-file write enable.
- `retire_count`  out  16: number of committed register writes, wrapping.

## Operation
- Two register ranks: M (EX/MEM) samples every `ex_*` input on each edge; W (MEM/WB) samples M's `alu_result`, `dest_addr`, `wb` and `mem_read` (load select) on each edge.
- Data memory address: M.alu_result[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo 2^ADDR_W.
- Store: when M.mem_write=1, `mem[addr] <= M.store_data` at the edge that ends the M cycle.
- Load: when M.mem_read=1 and M.mem_write=0, memory output register `mem_q <= mem[addr]` at that same edge.
- Same-address store in M followed by a load one cycle later: the load returns the stored data. The write completes at the earlier edge, so no bypass is needed.
- Load and store asserted together: treated as a store only. `mem_q` holds its value, and W's load select is 0, so `write_data` = alu_result.
- Write-back:
  - `write_en` = W.wb.
  - `write_addr` = W.dest_addr.
  - `write_data` = W.load ? mem_q : W.alu_result (combinational mux of registered values).
- `wb`=0: `write_en`=0, and `write_addr`/`write_data` still reflect W (don't-care for the consumer).
- `retire_count` increments by 1 on every edge where W.wb=1, and wraps from 0xFFFF to 0x0000.
- Memory contents are not affected by reset. The bench must initialise or write memory before reading it.

## Timing
- Inputs are presented in cycle N and sampled at edge E0. M is valid in cycle N+1, the memory write/read happens at E1, and W plus `mem_q` are valid in cycle N+2.
- Latency: two edges from input to `write_*`. The decode register file commits at E2.
- Throughput: one instruction per cycle. There are no stalls and no handshake; every cycle is a valid slot. A bubble is all-zero control (`ex_wb`=`ex_mem_read`=`ex_mem_write`=0).
- Reset, asynchronous: M and W are cleared immediately, so `write_en`=0, `write_addr`=0, `write_data`=0 (`mem_q` is cleared as well) and `retire_count`=0.
- Reset mid-operation: in-flight stores in M are dropped (no write occurs while reset is high), and in-flight loads and write-backs are lost.
- After reset deasserts, the first instruction reaches `write_*` two edges after it is presented.

## Structure
- Shared package `cpu_pkg`: `DATA_W`=16, `REG_ADDR_W`=3, and the bubble/default control values.
- One sub-module `data_mem`: single-port synchronous RAM with parameter ADDR_W, write enable, registered read output with read enable, and no reset of the array.
- The M/W ranks, the write-back mux and the counter live in the top level.

## Test plan
- Reset: assert `reset` mid-cycle with W.wb=1 -> `write_en`, `write_addr`, `write_data` and `retire_count` go to 0 immediately, without waiting for a clock edge.
- ALU write-back: `ex_alu_result`=0x1234, `ex_dest_addr`=5, `ex_wb`=1 at cycle N -> cycle N+2 shows `write_en`=1, `write_addr`=5, `write_data`=0x1234, and `retire_count` is +1 after E2.
- Store then load at the same address, back-to-back:
  - Cycle N: store 0xBEEF to address 0x0010.
  - Cycle N+1: load from 0x0010 with `ex_dest_addr`=2.
  - Required: cycle N+3 shows `write_en`=1, `write_addr`=2, `write_data`=0xBEEF.
- Address wrap: store 0xA5A5 with `ex_alu_result`=0x0103, then load with `ex_alu_result`=0x0003 -> `write_data`=0xA5A5.
- Load and store together: `ex_mem_read`=`ex_mem_write`=1, `ex_alu_result`=0x0020, `ex_store_data`=0x7777, `ex_wb`=1 -> mem[0x20]=0x7777 and `write_data`=0x0020.
- Counter wrap: preload to 65535 retirements (or force), then one more wb -> `retire_count`=0. Bubbles leave the counter unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, pipeline-rank record types and bubble values for the
// memory-access / write-back stage of the 16-bit pipelined processor.
package cpu_pkg;
   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int CNT_W      = 16;

   typedef logic [DATA_W-1:0]     data_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [CNT_W-1:0]      cnt_t;

   // EX/MEM rank: everything the decode stage pipes down to us.
   typedef struct packed {
      data_t     alu_result;
      data_t     store_data;
      reg_addr_t dest_addr;
      logic      mem_read;
      logic      mem_write;
      logic      wb;
   } m_rank_t;

   // MEM/WB rank: only what the write-back mux and the counter need.
   typedef struct packed {
      data_t     alu_result;
      reg_addr_t dest_addr;
      logic      wb;
      logic      load;
   } w_rank_t;

   // All-zero control is a bubble; data fields are cleared too so reset
   // presents zeros on the write port.
   localparam m_rank_t M_BUBBLE = '0;
   localparam w_rank_t W_BUBBLE = '0;

   // A simultaneous load+store behaves as a store only.
   function automatic logic is_load(input m_rank_t m);
      return m.mem_read & ~m.mem_write;
   endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: pipeline inputs from execute (ex_*) and the register-file
// write port plus retirement counter back towards decode.
//   master : upstream side, drives ex_*, observes write_* / retire_count
//   slave  : the stage itself
interface mem_wb_stage_if;
   import cpu_pkg::*;

   data_t     ex_alu_result;
   data_t     ex_store_data;
   reg_addr_t ex_dest_addr;
   logic      ex_mem_read;
   logic      ex_mem_write;
   logic      ex_wb;

   reg_addr_t write_addr;
   data_t     write_data;
   logic      write_en;
   cnt_t      retire_count;

   modport master (
      output ex_alu_result, ex_store_data, ex_dest_addr,
             ex_mem_read, ex_mem_write, ex_wb,
      input  write_addr, write_data, write_en, retire_count
   );

   modport slave (
      input  ex_alu_result, ex_store_data, ex_dest_addr,
             ex_mem_read, ex_mem_write, ex_wb,
      output write_addr, write_data, write_en, retire_count
   );
endinterface

// File: rtl/data_mem.sv
// data_mem: single-port synchronous data RAM, 2^ADDR_W x DATA_W.
//   clk, rst : clock; async active-high reset clears only the read register
//   we       : write wdata to mem[addr] at the rising edge
//   re       : capture mem[addr] into rdata at the rising edge (else hold)
//   rdata    : registered read data
// The array itself is never reset.
module data_mem
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  data_t             wdata,
   output data_t             rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   data_t mem [DEPTH];
   data_t rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage.
//   clk, reset : clock; async active-high reset clears M, W, mem_q, counter
//   bus        : ex_* inputs (sampled every edge, no stalls) and the
//                register-file write port write_addr/write_data/write_en,
//                plus retire_count (committed register writes, wrapping)
// Input presented in cycle N appears on write_* in cycle N+2.
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   mem_wb_stage_if.slave   bus
);
   m_rank_t m_q, m_d;
   w_rank_t w_q, w_d;
   cnt_t    cnt_q, cnt_d;
   data_t   mem_q;

   always_comb begin
      m_d            = M_BUBBLE;
      m_d.alu_result = bus.ex_alu_result;
      m_d.store_data = bus.ex_store_data;
      m_d.dest_addr  = bus.ex_dest_addr;
      m_d.mem_read   = bus.ex_mem_read;
      m_d.mem_write  = bus.ex_mem_write;
      m_d.wb         = bus.ex_wb;
   end

   always_comb begin
      w_d            = W_BUBBLE;
      w_d.alu_result = m_q.alu_result;
      w_d.dest_addr  = m_q.dest_addr;
      w_d.wb         = m_q.wb;
      w_d.load       = is_load(m_q);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (w_q.wb) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q   <= M_BUBBLE;
         w_q   <= W_BUBBLE;
         cnt_q <= '0;
      end else begin
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   // Address is the low ADDR_W bits; upper ALU bits wrap away. The store
   // lands at the end of the M cycle, so a load one slot behind reads it
   // straight from the array without a bypass. Reset also gates the write
   // so an in-flight store is dropped while reset is held.
   data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
      .clk   (clk),
      .rst   (reset),
      .we    (m_q.mem_write & ~reset),
      .re    (is_load(m_q)),
      .addr  (m_q.alu_result[ADDR_W-1:0]),
      .wdata (m_q.store_data),
      .rdata (mem_q)
   );

   assign bus.write_en     = w_q.wb;
   assign bus.write_addr   = w_q.dest_addr;
   assign bus.write_data   = w_q.load ? mem_q : w_q.alu_result;
   assign bus.retire_count = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenario tasks plus a randomized run checked
// against a program-order model (instructions applied one at a time to a
// plain memory array, result expected two slots later).
module tb_mem_wb_stage;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_wb_stage_if bus ();

   mem_wb_stage #(.ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  dst;
      logic [15:0] data;
      logic        wb;
   } exp_t;

   logic [15:0] mm [256];
   bit          mv [256];

   task automatic drive(input logic [15:0] alu, input logic [15:0] sd,
                        input logic [2:0] dst, input logic rd,
                        input logic wr, input logic wb);
      bus.ex_alu_result = alu;
      bus.ex_store_data = sd;
      bus.ex_dest_addr  = dst;
      bus.ex_mem_read   = rd;
      bus.ex_mem_write  = wr;
      bus.ex_wb         = wb;
   endtask

   task automatic bubble();
      drive(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bubble();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.write_en !== 1'b0 || bus.write_addr !== 3'd0 ||
          bus.write_data !== 16'h0 || bus.retire_count !== 16'h0) begin
         failures++;
         $display("FAIL reset_state: en=%b addr=%0d data=%h cnt=%0d, want all 0",
                  bus.write_en, bus.write_addr, bus.write_data, bus.retire_count);
      end
      drive(16'h00AA, 16'h0, 3'd3, 1'b0, 1'b0, 1'b1); step();
      drive(16'h00BB, 16'h0, 3'd4, 1'b0, 1'b0, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_data !== 16'h00BB || bus.retire_count !== 16'd1) begin
         failures++;
         $display("FAIL pre_reset: en=%b data=%h cnt=%0d, want 1/00bb/1",
                  bus.write_en, bus.write_data, bus.retire_count);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.write_en !== 1'b0 || bus.write_addr !== 3'd0 ||
          bus.write_data !== 16'h0 || bus.retire_count !== 16'h0) begin
         failures++;
         $display("FAIL async_reset: en=%b addr=%0d data=%h cnt=%0d, want all 0",
                  bus.write_en, bus.write_addr, bus.write_data, bus.retire_count);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset_drops_store();
      do_reset();
      drive(16'h0040, 16'h1111, 3'd0, 1'b0, 1'b1, 1'b0); step();
      bubble(); step(); step();
      drive(16'h0040, 16'h2222, 3'd0, 1'b0, 1'b1, 1'b0); step();
      bubble();
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(16'h0040, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd1 || bus.write_data !== 16'h1111) begin
         failures++;
         $display("FAIL reset_drops_store: en=%b addr=%0d data=%h, want 1/1/1111",
                  bus.write_en, bus.write_addr, bus.write_data);
      end
   endtask

   task automatic test_alu_wb();
      do_reset();
      drive(16'h1234, 16'h0, 3'd5, 1'b0, 1'b0, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd5 ||
          bus.write_data !== 16'h1234 || bus.retire_count !== 16'd0) begin
         failures++;
         $display("FAIL alu_wb: en=%b addr=%0d data=%h cnt=%0d, want 1/5/1234/0",
                  bus.write_en, bus.write_addr, bus.write_data, bus.retire_count);
      end
      step();
      checks++;
      if (bus.write_en !== 1'b0 || bus.retire_count !== 16'd1) begin
         failures++;
         $display("FAIL alu_wb_count: en=%b cnt=%0d, want 0/1",
                  bus.write_en, bus.retire_count);
      end
   endtask

   task automatic test_store_load();
      do_reset();
      drive(16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0); step();
      drive(16'h0010, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd2 || bus.write_data !== 16'hBEEF) begin
         failures++;
         $display("FAIL store_load: en=%b addr=%0d data=%h, want 1/2/beef",
                  bus.write_en, bus.write_addr, bus.write_data);
      end
   endtask

   task automatic test_addr_wrap();
      do_reset();
      drive(16'h0103, 16'hA5A5, 3'd0, 1'b0, 1'b1, 1'b0); step();
      drive(16'h0003, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd7 || bus.write_data !== 16'hA5A5) begin
         failures++;
         $display("FAIL addr_wrap: en=%b addr=%0d data=%h, want 1/7/a5a5",
                  bus.write_en, bus.write_addr, bus.write_data);
      end
   endtask

   task automatic test_load_store_both();
      do_reset();
      drive(16'h0020, 16'h7777, 3'd6, 1'b1, 1'b1, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_addr !== 3'd6 || bus.write_data !== 16'h0020) begin
         failures++;
         $display("FAIL both_wb: en=%b addr=%0d data=%h, want 1/6/0020",
                  bus.write_en, bus.write_addr, bus.write_data);
      end
      drive(16'h0020, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1); step();
      bubble(); step();
      checks++;
      if (bus.write_data !== 16'h7777) begin
         failures++;
         $display("FAIL both_mem: data=%h, want 7777", bus.write_data);
      end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      for (int i = 0; i < 65535; i++) begin
         drive(16'(i), 16'h0, 3'(i), 1'b0, 1'b0, 1'b1);
         step();
      end
      bubble();
      repeat (3) step();
      checks++;
      if (bus.retire_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL count_full: cnt=%h, want ffff", bus.retire_count);
      end
      repeat (4) step();
      checks++;
      if (bus.retire_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL count_bubbles: cnt=%h, want ffff", bus.retire_count);
      end
      drive(16'h0001, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1); step();
      bubble();
      repeat (3) step();
      checks++;
      if (bus.retire_count !== 16'h0000) begin
         failures++;
         $display("FAIL count_wrap: cnt=%h, want 0000", bus.retire_count);
      end
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        e;
      logic [15:0] cnt;
      logic [15:0] alu, sd;
      logic [7:0]  a;
      logic [2:0]  dst;
      logic        rd, wr, wb;
      int          kind;
      do_reset();
      cnt = 16'h0;
      for (int k = 0; k < 256; k++) mv[k] = 1'b0;
      for (int i = 0; i < 402; i++) begin
         alu  = {8'($urandom), 4'h0, 4'($urandom)};
         sd   = 16'($urandom);
         dst  = 3'($urandom);
         wb   = 1'($urandom);
         a    = alu[7:0];
         kind = (i >= 400) ? 4 : int'($urandom_range(0, 4));
         if (kind == 2 && !mv[a]) kind = 1;
         rd = 1'b0; wr = 1'b0;
         e.dst = dst; e.data = alu;
         case (kind)
            1: begin wr = 1'b1; mm[a] = sd; mv[a] = 1'b1; end
            2: begin rd = 1'b1; wb = 1'b1; e.data = mm[a]; end
            3: begin rd = 1'b1; wr = 1'b1; mm[a] = sd; mv[a] = 1'b1; end
            4: wb = 1'b0;
            default: ;
         endcase
         e.wb = wb;
         drive(alu, sd, dst, rd, wr, wb);
         q.push_back(e);
         step();
         if (q.size() >= 2) begin
            e = q.pop_front();
            checks++;
            if (bus.write_en !== e.wb || bus.write_addr !== e.dst ||
                bus.write_data !== e.data || bus.retire_count !== cnt) begin
               failures++;
               $display("FAIL random[%0d]: en=%b addr=%0d data=%h cnt=%0d, want %b/%0d/%h/%0d",
                        i, bus.write_en, bus.write_addr, bus.write_data, bus.retire_count,
                        e.wb, e.dst, e.data, cnt);
            end
            if (e.wb) cnt = cnt + 16'd1;
         end
      end
      bubble();
   endtask

   initial begin
      bubble();
      test_reset();
      test_reset_drops_store();
      test_alu_wb();
      test_store_load();
      test_addr_wrap();
      test_load_store_both();
      test_random();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
